// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor that adds CHUNK bits per clock, LSB chunk first.
// Optional signed-overflow flag is enabled with the CHUNKED_ADDER_OVF_EN macro.
module chunked_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ov
);

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic              carry_r;
    logic [IW-1:0]     idx_r;
    logic [WIDTH-1:0]  s_r;
    logic              co_r;
    logic              ready_r;
    logic              done_r;
    logic              ready_s;
    logic              done_s;
    logic              last_s;
    logic [CHUNK-1:0]  a_chunk_s;
    logic [CHUNK-1:0]  b_chunk_s;
    logic [CHUNK:0]    sum_s;

    assign last_s = (idx_r == IW'(N - 1));

    // Current chunk of the captured operands and its sum with the running carry
    always_comb begin
        a_chunk_s = a_r[idx_r*CHUNK +: CHUNK];
        b_chunk_s = b_r[idx_r*CHUNK +: CHUNK];
        sum_s     = {1'b0, a_chunk_s} + {1'b0, b_chunk_s} + {{CHUNK{1'b0}}, carry_r};
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = FIN;
                end else begin
                    state_s = RUN;
                end
            end
            FIN:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM output decode, from the next state so the flags line up with it
    always_comb begin
        ready_s = 1'b0;
        done_s  = 1'b0;
        case (state_s)
            IDLE:    ready_s = 1'b1;
            FIN:     done_s  = 1'b1;
            default: begin
                ready_s = 1'b0;
                done_s  = 1'b0;
            end
        endcase
    end

    // Registered status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_r <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            ready_r <= ready_s;
            done_r  <= done_s;
        end
    end

    // Operand capture and per-chunk accumulation; subtract is A + ~B + 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            idx_r   <= {IW{1'b0}};
            s_r     <= {WIDTH{1'b0}};
            co_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= sub ? ~b : b;
                        carry_r <= sub ? 1'b1 : ci;
                        idx_r   <= {IW{1'b0}};
                    end
                end
                RUN: begin
                    s_r[idx_r*CHUNK +: CHUNK] <= sum_s[CHUNK-1:0];
                    carry_r                   <= sum_s[CHUNK];
                    idx_r                     <= idx_r + IW'(1);
                    if (last_s) begin
                        co_r <= sum_s[CHUNK];
                    end
                end
                default: begin
                    carry_r <= carry_r;
                end
            endcase
        end
    end

`ifdef CHUNKED_ADDER_OVF_EN
    logic ov_r;
    logic msb_cin_s;

    // Carry into the MSB is recovered from the MSB sum bit and its two inputs
    assign msb_cin_s = a_chunk_s[CHUNK-1] ^ b_chunk_s[CHUNK-1] ^ sum_s[CHUNK-1];

    // Signed overflow captured on the final chunk, held until the next result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ov_r <= 1'b0;
        end else if ((state_r == RUN) && last_s) begin
            ov_r <= msb_cin_s ^ sum_s[CHUNK];
        end else begin
            ov_r <= ov_r;
        end
    end

    assign ov = ov_r;
`else
    assign ov = 1'b0;
`endif

    assign ready = ready_r;
    assign done  = done_r;
    assign s     = s_r;
    assign co    = co_r;

endmodule

// File: tb/tb_chunked_adder.sv
// Directed self-checking bench for chunked_adder (16/4 instance and an 8/8 instance).
module tb_chunked_adder;

`ifdef CHUNKED_ADDER_OVF_EN
    localparam logic OVF = 1'b1;
`else
    localparam logic OVF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start, sub, ci;
    logic [15:0] a, b;
    logic        ready, done, co, ov;
    logic [15:0] s;

    logic        start8, sub8, ci8;
    logic [7:0]  a8, b8;
    logic        ready8, done8, co8, ov8;
    logic [7:0]  s8;

    int total = 0;
    int bad   = 0;

    chunked_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .ci(ci),
        .ready(ready), .done(done), .s(s), .co(co), .ov(ov)
    );

    chunked_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .ci(ci8),
        .ready(ready8), .done(done8), .s(s8), .co(co8), .ov(ov8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic tci, input logic tsub,
                          input logic [15:0] es, input logic eco, input logic eov);
        int n;
        a = ta; b = tb_v; ci = tci; sub = tsub; start = 1'b1;
        tick();
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); sub = ~tsub; ci = ~tci;
        chk({tag, "_ready_lo"}, 32'(ready), 32'd0);
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd4);
        chk({tag, "_s"}, 32'(s), 32'(es));
        chk({tag, "_co"}, 32'(co), 32'(eco));
        chk({tag, "_ov"}, 32'(ov), 32'(eov));
        chk({tag, "_ready_fin"}, 32'(ready), 32'd0);
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_ready_idle"}, 32'(ready), 32'd1);
    endtask

    initial begin
        int n;
        int ndone;
        rst = 1'b1; start = 1'b0; sub = 1'b0; ci = 1'b0; a = 16'h0000; b = 16'h0000;
        start8 = 1'b0; sub8 = 1'b0; ci8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        #12;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_co", 32'(co), 32'd0);
        chk("rst_ov", 32'(ov), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        run_op("basic",   16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
        run_op("wrap",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("wrap_ci", 16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0);
        run_op("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_pos", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
        run_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, OVF);
        run_op("ovf_sub", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, OVF);

        // Idle with changing inputs must hold the last result
        for (int i = 0; i < 3; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            tick();
        end
        chk("hold_s", 32'(s), 32'h7FFF);
        chk("hold_co", 32'(co), 32'd1);
        chk("hold_ov", 32'(ov), 32'(OVF));

        // Start held high and operands wiggled during RUN: one Done, first operands
        a = 16'h1111; b = 16'h2222; ci = 1'b0; sub = 1'b0; start = 1'b1;
        tick();
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (i >= 3) start = 1'b0;
            a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
            tick();
            if (done) begin
                ndone++;
                chk("held_start_s", 32'(s), 32'h3333);
            end
        end
        chk("held_start_ndone", 32'(ndone), 32'd1);

        // Reset during the second RUN cycle aborts without Done
        a = 16'h00FF; b = 16'h0001; sub = 1'b0; ci = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("abort_s", 32'(s), 32'd0);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        tick();
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) ndone++;
        end
        chk("abort_ndone", 32'(ndone), 32'd0);
        run_op("after_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

        // Single-chunk instance
        a8 = 8'hF0; b8 = 8'h10; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 20) begin
            tick();
            n++;
        end
        chk("w8_latency", 32'(n), 32'd1);
        chk("w8_s", 32'(s8), 32'h00);
        chk("w8_co", 32'(co8), 32'd1);
        chk("w8_ov", 32'(ov8), 32'd0);
        tick();
        chk("w8_done_pulse", 32'(done8), 32'd0);
        chk("w8_ready", 32'(ready8), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
